// File: rtl/canv_draw_agu_pkg.sv
// Shared widths, pipeline payload type and clip test for the canvas draw AGU.
// Widths follow the gfx codebase: signed CORDW coordinates, WORD-bit vram words and ADDRW-bit word addresses.
package canv_draw_agu_pkg;

    localparam int CORDW   = 16;
    localparam int WORD    = 32;
    localparam int ADDRW   = 20;
    localparam int PIX_IDW = $clog2(WORD);
    localparam int SHIFTW  = 3;
    localparam int APIXW   = ADDRW + PIX_IDW;
    localparam int CLIPW   = 16;

    // Per-pixel config captured at acceptance, so a config change only affects later pixels.
    typedef struct packed {
        logic [WORD-1:0]   colour;
        logic [ADDRW-1:0]  base;
        logic [SHIFTW-1:0] shift;
    } pix_cfg_t;

    // Coordinates are signed and the canvas size is unsigned, so one extra bit keeps both ranges exact.
    function automatic logic is_clipped(
        input logic [CORDW-1:0] px,
        input logic [CORDW-1:0] py,
        input logic [CORDW-1:0] w,
        input logic [CORDW-1:0] h
    );
        logic signed [CORDW:0] xs, ys, ws, hs;
        xs = {px[CORDW-1], px};
        ys = {py[CORDW-1], py};
        ws = {1'b0, w};
        hs = {1'b0, h};
        return px[CORDW-1] || py[CORDW-1] || (xs >= ws) || (ys >= hs);
    endfunction

endpackage

// File: rtl/canv_wmask_gen.sv
// Combinational write-mask and replicated write-data generator for packed-pixel vram words.
// Also used by the blitter.
module canv_wmask_gen
    import canv_draw_agu_pkg::*;
(
    input  logic [SHIFTW-1:0]  addr_shift,
    input  logic [PIX_IDW-1:0] pix_id,
    input  logic [WORD-1:0]    colour,
    output logic [WORD-1:0]    wmask,
    output logic [WORD-1:0]    wdata
);

    localparam int OFFW = 2 * PIX_IDW + 1;
    localparam logic [PIX_IDW:0] WORD_B = (PIX_IDW + 1)'(WORD);
    localparam logic [PIX_IDW:0] ONE_B  = (PIX_IDW + 1)'(1);

    logic [PIX_IDW:0]   bpp;
    logic [PIX_IDW-1:0] lane;
    logic [WORD-1:0]    field;
    logic [OFFW-1:0]    bit_off;

    // NOTE: every output of this block is assigned on every pass, so no latch can be inferred.
    always_comb begin
        bpp     = WORD_B >> addr_shift;
        lane    = PIX_IDW'(bpp - ONE_B);
        field   = {WORD{1'b1}} >> (WORD_B - bpp);
        bit_off = OFFW'(pix_id) * OFFW'(bpp);
        wmask   = field << bit_off;
        // bpp is a power of two, so bit k of every slot maps to colour bit (k mod bpp).
        for (int k = 0; k < WORD; k++) begin
            wdata[k] = colour[PIX_IDW'(k) & lane];
        end
    end

endmodule

// File: rtl/canv_draw_agu.sv
// Canvas draw AGU: clips pixel writes to the canvas and turns survivors into vram word writes.
// Three-stage pipeline with one global advance enable driven by the output handshake.
module canv_draw_agu
    import canv_draw_agu_pkg::*;
(
    input  logic               clk_sys,
    input  logic               rst_sys,
    input  logic [ADDRW-1:0]   addr_base,
    input  logic [SHIFTW-1:0]  addr_shift,
    input  logic [CORDW-1:0]   canv_w,
    input  logic [CORDW-1:0]   canv_h,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [CORDW-1:0]   x,
    input  logic [CORDW-1:0]   y,
    input  logic [WORD-1:0]    colour,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [ADDRW-1:0]   addr,
    output logic [PIX_IDW-1:0] pix_id,
    output logic [WORD-1:0]    wdata,
    output logic [WORD-1:0]    wmask,
    output logic [CLIPW-1:0]   clip_cnt,
    output logic               busy
);

    logic               adv, accept, clip;
    logic               v1, v2;
    logic [CORDW-1:0]   x1;
    logic [APIXW-1:0]   row1, addr_pix2;
    pix_cfg_t           cfg1, cfg2;
    logic [PIX_IDW-1:0] pid_mask, pid_next;
    logic [WORD-1:0]    wmask_next, wdata_next;

    assign adv      = !m_valid || m_ready;
    assign s_ready  = adv;
    assign accept   = s_valid && adv;
    assign clip     = is_clipped(x, y, canv_w, canv_h);
    assign busy     = v1 || v2 || m_valid;
    assign pid_mask = PIX_IDW'((32'd1 << cfg2.shift) - 32'd1);
    assign pid_next = addr_pix2[PIX_IDW-1:0] & pid_mask;

    canv_wmask_gen u_wmask_gen (
        .addr_shift (cfg2.shift),
        .pix_id     (pid_next),
        .colour     (cfg2.colour),
        .wmask      (wmask_next),
        .wdata      (wdata_next)
    );

    // NOTE: datapath registers carry no reset; their contents only matter when the matching valid bit is set.
    always_ff @(posedge clk_sys) begin
        if (adv) begin
            x1        <= x;
            row1      <= APIXW'(y) * APIXW'(canv_w);
            cfg1      <= '{colour: colour, base: addr_base, shift: addr_shift};
            cfg2      <= cfg1;
            addr_pix2 <= row1 + APIXW'(x1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge clk_sys or posedge rst_sys) begin
        if (rst_sys) begin
            v1       <= 1'b0;
            v2       <= 1'b0;
            m_valid  <= 1'b0;
            addr     <= '0;
            pix_id   <= '0;
            wdata    <= '0;
            wmask    <= '0;
            clip_cnt <= '0;
        end else begin
            if (adv) begin
                v1      <= accept && !clip;
                v2      <= v1;
                m_valid <= v2;
                if (v2) begin
                    addr   <= cfg2.base + ADDRW'(addr_pix2 >> cfg2.shift);
                    pix_id <= pid_next;
                    wdata  <= wdata_next;
                    wmask  <= wmask_next;
                end
            end
            if (accept && clip && clip_cnt != '1) begin
                clip_cnt <= clip_cnt + 16'd1;
            end
        end
    end

endmodule
